// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic stage register with a two-entry skid buffer,
// freeze/flush control and saturating stall/squash counters.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  squash_q, squash_d;
  logic [CNT_W:0]    squash_sum;
  logic              main_valid, skid_valid;
  logic              in_xfer, out_xfer;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // flush gates out_valid too, so a squashed head is never consumed
  assign out_valid = main_valid & ~freeze & ~flush;
  assign in_ready  = ~skid_valid & ~freeze & ~flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  assign out_data   = main_q;
  assign occupancy  = state_q;
  assign stall_cnt  = stall_q;
  assign squash_cnt = squash_q;

  assign squash_sum = {1'b0, squash_q}
                    + (CNT_W+1)'(main_valid)
                    + (CNT_W+1)'(skid_valid);

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    stall_d  = stall_q;
    squash_d = squash_q;

    if (out_valid && !out_ready && stall_q != CNT_MAX) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush) begin
      state_d  = EMPTY;
      main_d   = NOP_VALUE;
      skid_d   = NOP_VALUE;
      squash_d = (squash_sum > {1'b0, CNT_MAX}) ? CNT_MAX
                                                : squash_sum[CNT_W-1:0];
    end else if (!freeze) begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= EMPTY;
      main_q   <= NOP_VALUE;
      skid_q   <= NOP_VALUE;
      stall_q  <= '0;
      squash_q <= '0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      stall_q  <= stall_d;
      squash_q <= squash_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed plan plus random traffic, checked each
// cycle against a queue-based reference of the stage.
module tb_pipe_skid_reg;

  localparam int DW = 64;
  localparam logic [DW-1:0] NOP = 64'hDEAD_BEEF_0000_0013;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          freeze = 1'b0;
  logic          flush = 1'b0;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt, squash_cnt;

  logic          in_ready2, out_valid2;
  logic [DW-1:0] out_data2;
  logic [1:0]    occupancy2;
  logic [1:0]    stall2, squash2;

  always #5 CLK = ~CLK;

  pipe_skid_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .freeze(freeze), .flush(flush), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
  );

  pipe_skid_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
    .freeze(freeze), .flush(flush), .occupancy(occupancy2),
    .stall_cnt(stall2), .squash_cnt(squash2)
  );

  // reference: pending payloads in order, plus unbounded counters
  logic [DW-1:0] mq[$];
  logic [DW-1:0] idle_data = NOP;
  longint        m_stall = 0;
  longint        m_squash = 0;
  bit            checking = 0;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(string nm, logic [63:0] act,
                                logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (64'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge CLK) begin
    int sz;
    bit ov, ox, ix;
    sz = mq.size();
    ov = (sz > 0) && !freeze && !flush;
    if (checking && RST) begin
      check("occupancy", 64'(occupancy), 64'(sz));
      check("out_valid", 64'(out_valid), 64'(ov));
      check("in_ready", 64'(in_ready),
            64'((sz < 2) && !freeze && !flush));
      check("out_data", out_data, (sz > 0) ? mq[0] : idle_data);
      check("stall_cnt", 64'(stall_cnt), 64'(sat(m_stall, 16)));
      check("squash_cnt", 64'(squash_cnt), 64'(sat(m_squash, 16)));
      check("occupancy2", 64'(occupancy2), 64'(sz));
      check("out_data2", out_data2, (sz > 0) ? mq[0] : idle_data);
      check("stall2", 64'(stall2), 64'(sat(m_stall, 2)));
      check("squash2", 64'(squash2), 64'(sat(m_squash, 2)));
    end
    if (!RST) begin
      mq.delete();
      idle_data = NOP;
      m_stall = 0;
      m_squash = 0;
    end else if (flush) begin
      m_squash += sz;
      mq.delete();
      idle_data = NOP;
    end else if (!freeze) begin
      ox = (sz > 0) && out_ready;
      ix = in_valid && (sz < 2);
      if (ov && !out_ready) m_stall++;
      if (ox) idle_data = mq.pop_front();
      if (ix) mq.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    checking = 1;
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_odata", out_data, NOP);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_squash", 64'(squash_cnt), 64'd0);
    check("rst_iready", 64'(in_ready), 64'd1);

    // stream 1,2,3 at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data = 64'(i);
      tick();
      check("stream_data", out_data, 64'(i));
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    tick();

    // fill to FULL under backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'hA;
    tick();
    in_data = 64'hB;
    tick();
    in_valid = 1'b0;
    check("full_occ", 64'(occupancy), 64'd2);
    check("full_iready", 64'(in_ready), 64'd0);

    // freeze while FULL
    freeze = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("frz_ovalid", 64'(out_valid), 64'd0);
      check("frz_iready", 64'(in_ready), 64'd0);
      check("frz_occ", 64'(occupancy), 64'd2);
    end
    freeze = 1'b0;
    #1;
    check("drain_a", out_data, 64'hA);
    tick();
    check("drain_b", out_data, 64'hB);
    tick();
    check("drain_occ", 64'(occupancy), 64'd0);

    // flush beats freeze and a pending push
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'hC;
    tick();
    in_data = 64'hD;
    tick();
    freeze = 1'b1;
    flush = 1'b1;
    in_data = 64'hE;
    #1;
    check("flush_iready", 64'(in_ready), 64'd0);
    tick();
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_odata", out_data, NOP);
    check("flush_squash", 64'(squash_cnt), 64'd2);
    flush = 1'b0;
    freeze = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush_noaccept", 64'(occupancy), 64'd0);

    // 2-bit stall counter saturates
    in_valid = 1'b1;
    in_data = 64'hF;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("sat_stall", 64'(stall2), 64'd3);
    tick();
    check("sat_hold", 64'(stall2), 64'd3);

    // reset while FULL
    in_valid = 1'b1;
    in_data = 64'h11;
    tick();
    in_valid = 1'b0;
    check("prerst_occ", 64'(occupancy), 64'd2);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    check("rst2_occ", 64'(occupancy), 64'd0);
    check("rst2_ovalid", 64'(out_valid), 64'd0);
    check("rst2_odata", out_data, NOP);
    check("rst2_stall", 64'(stall_cnt), 64'd0);
    check("rst2_squash", 64'(squash_cnt), 64'd0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(9) < 7);
      freeze    = ($urandom_range(9) == 0);
      flush     = ($urandom_range(24) == 0);
      RST       = ($urandom_range(299) != 0);
      tick();
    end

    RST = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("final_occ", 64'(occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
